// File: rtl/item_memory_fetch_ctrl.sv
// Item memory address sequencer: linear port-B sweep from a base, port-A levels from the sample stream.
// Port A is a zero-latency pass-through; ports stall independently on their own ready, done pulses once both finish.
module item_memory_fetch_ctrl #(
    parameter int ImAddrWidth = 32,
    parameter int DataWidth   = 8,
    parameter int CountWidth  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   start_i,
    input  logic [CountWidth-1:0]  num_items_i,
    input  logic [ImAddrWidth-1:0] base_addr_b_i,
    input  logic [DataWidth-1:0]   data_i,
    input  logic                   data_valid_i,
    output logic                   data_ready_o,
    output logic [ImAddrWidth-1:0] im_a_addr_o,
    output logic                   im_a_addr_valid_o,
    input  logic                   im_a_addr_ready_i,
    output logic [ImAddrWidth-1:0] im_b_addr_o,
    output logic                   im_b_addr_valid_o,
    input  logic                   im_b_addr_ready_i,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CountWidth-1:0]  cnt_a_q, cnt_a_d;
    logic [CountWidth-1:0]  cnt_b_q, cnt_b_d;
    logic [CountWidth-1:0]  num_q, num_d;
    logic [ImAddrWidth-1:0] base_q, base_d;

    logic run;
    logic a_open;
    logic b_open;
    logic a_fire;
    logic b_fire;

    always_comb begin
        run    = (state_q == RUN);
        // A port still owes addresses only while its count is below the target.
        a_open = run && (cnt_a_q < num_q);
        b_open = run && (cnt_b_q < num_q);
        a_fire = a_open && data_valid_i && im_a_addr_ready_i;
        b_fire = b_open && im_b_addr_ready_i;

        im_a_addr_o       = run ? ImAddrWidth'(data_i) : '0;
        im_a_addr_valid_o = a_open && data_valid_i;
        data_ready_o      = a_open && im_a_addr_ready_i;
        im_b_addr_o       = run ? (base_q + ImAddrWidth'(cnt_b_q)) : '0;
        im_b_addr_valid_o = b_open;
        busy_o            = (state_q != IDLE);
        done_o            = (state_q == DONE);
    end

    always_comb begin
        state_d = state_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        num_d   = num_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_items_i != '0) begin
                        num_d   = num_items_i;
                        base_d  = base_addr_b_i;
                        cnt_a_d = '0;
                        cnt_b_d = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (a_fire) begin
                    cnt_a_d = cnt_a_q + CountWidth'(1);
                end
                if (b_fire) begin
                    cnt_b_d = cnt_b_q + CountWidth'(1);
                end
                if ((cnt_a_d == num_q) && (cnt_b_d == num_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Dropping en_i behaves exactly like reset: the pass is abandoned silently.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            state_q <= IDLE;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            num_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            num_q   <= num_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_item_memory_fetch_ctrl.sv
// Bench for item_memory_fetch_ctrl: per-cycle comparison against a pass-level model plus literal pass results.
module tb_item_memory_fetch_ctrl;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk           = 1'b0;
    logic          rst_ni        = 1'b0;
    logic          en_i          = 1'b0;
    logic          start_i       = 1'b0;
    logic [CW-1:0] num_items_i   = '0;
    logic [AW-1:0] base_addr_b_i = '0;
    logic [DW-1:0] data_i        = '0;
    logic          data_valid_i  = 1'b0;
    logic          a_rdy         = 1'b1;
    logic          b_rdy         = 1'b1;
    logic          data_ready_o;
    logic [AW-1:0] im_a_addr_o;
    logic          im_a_addr_valid_o;
    logic [AW-1:0] im_b_addr_o;
    logic          im_b_addr_valid_o;
    logic          busy_o;
    logic          done_o;

    item_memory_fetch_ctrl #(.ImAddrWidth(AW), .DataWidth(DW), .CountWidth(CW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .en_i             (en_i),
        .start_i          (start_i),
        .num_items_i      (num_items_i),
        .base_addr_b_i    (base_addr_b_i),
        .data_i           (data_i),
        .data_valid_i     (data_valid_i),
        .data_ready_o     (data_ready_o),
        .im_a_addr_o      (im_a_addr_o),
        .im_a_addr_valid_o(im_a_addr_valid_o),
        .im_a_addr_ready_i(a_rdy),
        .im_b_addr_o      (im_b_addr_o),
        .im_b_addr_valid_o(im_b_addr_valid_o),
        .im_b_addr_ready_i(b_rdy),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_q(input string nm, input logic [31:0] got[$], input logic [31:0] exp[$]);
        check({nm, "_count"}, got.size(), exp.size());
        foreach (exp[i]) begin
            if (i < got.size()) check(nm, got[i], exp[i]);
        end
    endtask

    // Pass-level model: is a pass running, how many items each port has delivered, end-of-pass flag.
    bit          m_run  = 1'b0;
    bit          m_done = 1'b0;
    int          m_na   = 0;
    int          m_nb   = 0;
    int          m_num  = 0;
    logic [31:0] m_base = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_ni || !en_i) begin
            m_run = 0; m_done = 0; m_na = 0; m_nb = 0; m_num = 0; m_base = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_run) begin
            if (data_valid_i && a_rdy && m_na < m_num) m_na++;
            if (b_rdy && m_nb < m_num) m_nb++;
            if (m_na == m_num && m_nb == m_num) begin
                m_run  = 0;
                m_done = 1;
            end
        end else if (start_i) begin
            if (num_items_i != 0) begin
                m_run = 1; m_num = int'(num_items_i); m_base = base_addr_b_i; m_na = 0; m_nb = 0;
            end else begin
                m_done = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("a_valid", im_a_addr_valid_o, m_run && data_valid_i && (m_na < m_num));
        check("a_ready", data_ready_o, m_run && a_rdy && (m_na < m_num));
        check("a_addr", im_a_addr_o, m_run ? {24'h0, data_i} : 32'h0);
        check("b_valid", im_b_addr_valid_o, m_run && (m_nb < m_num));
        check("b_addr", im_b_addr_o, m_run ? m_base + 32'(m_nb) : 32'h0);
        check("busy", busy_o, m_run || m_done);
        check("done", done_o, m_done);
    end

    // Stimulus state and observed traffic.
    logic [DW-1:0] src[$];
    logic [31:0]   aq[$];
    logic [31:0]   bq[$];
    logic [31:0]   eq[$];
    int            dq[$];
    int            done_cnt = 0;
    int            bstall   = 0;
    bit            toggle   = 0;
    bit            vphase   = 0;
    int            t0       = 0;

    task automatic tick();
        bit hs;
        @(negedge clk);
        hs = data_valid_i && data_ready_o;
        if (hs) aq.push_back(im_a_addr_o);
        if (im_b_addr_valid_o && b_rdy) bq.push_back(im_b_addr_o);
        if (done_o) begin
            done_cnt++;
            dq.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (hs && src.size() > 0) void'(src.pop_front());
        if (bstall > 0) bstall--;
        vphase       = !vphase;
        b_rdy        = (bstall == 0);
        data_valid_i = (src.size() > 0) && (!toggle || vphase);
        data_i       = (src.size() > 0) ? src[0] : '0;
    endtask

    task automatic setup(input bit tg, input int stall);
        aq.delete(); bq.delete(); dq.delete();
        done_cnt = 0; toggle = tg; bstall = stall; vphase = 0;
        b_rdy = (stall == 0);
    endtask

    task automatic start_pass(input int num, input logic [31:0] base);
        num_items_i   = CW'(num);
        base_addr_b_i = base;
        start_i       = 1'b1;
        tick();
        start_i = 1'b0;
        t0      = cyc;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        int n = 0;
        while (done_cnt == 0 && n < maxc) begin
            tick();
            n++;
        end
        check({nm, "_done_seen"}, done_cnt, 1);
        tick();
        tick();
        check({nm, "_single_done"}, done_cnt, 1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", busy_o, 0);
        check("rst_bvalid", im_b_addr_valid_o, 0);
        check("rst_baddr", im_b_addr_o, 0);
        rst_ni = 1'b1;
        en_i   = 1'b1;
        tick();

        // Basic pass
        setup(0, 0);
        src = '{8'd3, 8'd7, 8'd1, 8'd9};
        start_pass(4, 32'h100);
        wait_done("basic", 30);
        check("basic_latency", dq[0] - t0, 4);
        eq = '{32'h100, 32'h101, 32'h102, 32'h103};
        check_q("basic_b", bq, eq);
        eq = '{32'd3, 32'd7, 32'd1, 32'd9};
        check_q("basic_a", aq, eq);

        // Port B held off for the first five RUN cycles
        setup(0, 6);
        src = '{8'd5, 8'd6, 8'd7};
        start_pass(3, 32'h20);
        wait_done("bp", 30);
        check("bp_latency", dq[0] - t0, 8);
        eq = '{32'h20, 32'h21, 32'h22};
        check_q("bp_b", bq, eq);
        eq = '{32'd5, 32'd6, 32'd7};
        check_q("bp_a", aq, eq);

        // Source valid alternates
        setup(1, 0);
        src = '{8'h11, 8'h22};
        start_pass(2, 32'h300);
        wait_done("stall", 30);
        check("stall_latency", dq[0] - t0, 3);
        eq = '{32'h11, 32'h22};
        check_q("stall_a", aq, eq);

        // Empty pass
        setup(0, 0);
        src = '{8'd1};
        start_pass(0, 32'h500);
        wait_done("empty", 10);
        check("empty_latency", dq[0] - t0, 0);
        check("empty_b_count", bq.size(), 0);
        check("empty_a_count", aq.size(), 0);

        // Address wrap
        setup(0, 0);
        src = '{8'd1, 8'd2, 8'd3};
        start_pass(3, 32'hFFFF_FFFE);
        wait_done("wrap", 30);
        eq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
        check_q("wrap_b", bq, eq);

        // Abort via en_i, then a fresh pass
        setup(0, 0);
        src = '{8'd1, 8'd2, 8'd3, 8'd4};
        start_pass(4, 32'h200);
        tick();
        en_i = 1'b0;
        tick();
        en_i = 1'b1;
        check("abort_busy", busy_o, 0);
        check("abort_bvalid", im_b_addr_valid_o, 0);
        repeat (3) tick();
        check("abort_no_done", done_cnt, 0);
        setup(0, 0);
        src = '{8'd8, 8'd9};
        start_pass(2, 32'h40);
        wait_done("restart", 30);
        eq = '{32'h40, 32'h41};
        check_q("restart_b", bq, eq);
        eq = '{32'd8, 32'd9};
        check_q("restart_a", aq, eq);

        // start_i held high: a second pass starts only from IDLE
        setup(0, 0);
        src = '{8'd1, 8'd2, 8'd3, 8'd4};
        num_items_i   = CW'(2);
        base_addr_b_i = 32'h60;
        start_i       = 1'b1;
        tick();
        t0 = cyc;
        for (int n = 0; n < 20 && done_cnt < 2; n++) tick();
        start_i = 1'b0;
        check("hold_dones", done_cnt, 2);
        if (dq.size() == 2) begin
            check("hold_first", dq[0] - t0, 2);
            check("hold_second", dq[1] - t0, 6);
        end
        eq = '{32'h60, 32'h61, 32'h60, 32'h61};
        check_q("hold_b", bq, eq);
        tick();

        // Reset during DONE
        setup(0, 0);
        src = '{8'd4};
        start_pass(1, 32'h50);
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("rst_done_busy", busy_o, 0);
        tick();
        check("rst_done_count", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
